// File: rtl/axi4_globals_pkg.sv
// Shared AXI4 encodings for the slave-side write path: burst, size and response codes
// plus the write responder FSM states.
package axi4_globals_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED    = 2'b00,
      BURST_INCR     = 2'b01,
      BURST_WRAP     = 2'b10,
      BURST_RESERVED = 2'b11
   } awburst_e;

   typedef enum logic [2:0] {
      SIZE_1B   = 3'd0,
      SIZE_2B   = 3'd1,
      SIZE_4B   = 3'd2,
      SIZE_8B   = 3'd3,
      SIZE_16B  = 3'd4,
      SIZE_32B  = 3'd5,
      SIZE_64B  = 3'd6,
      SIZE_128B = 3'd7
   } awsize_e;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } bresp_e;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } write_responder_state_e;

   // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
   function automatic logic wrap_len_legal(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage

// File: rtl/axi4_slave_aw_fifo.sv
// Outstanding write-address queue: push lands in the next cycle, head is read combinationally.
// Pushes while full and pops while empty are ignored; full/empty come straight from the pointers.
module axi4_slave_aw_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW:0]      wr_ptr;
   logic [PW:0]      rd_ptr;

   // Extra pointer bit separates the full case from the empty case.
   assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign pop_data = mem[rd_ptr[PW-1:0]];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            mem[wr_ptr[PW-1:0]] <= push_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/axi4_slave_write_responder.sv
// AXI4 slave write responder: queues AW, consumes W beats into byte-strobed memory writes
// (one cycle after each beat) and returns one B per burst; awready low only while the AW queue is full.
module axi4_slave_write_responder
   import axi4_globals_pkg::*;
#(
   parameter int                       ADDRESS_WIDTH          = 32,
   parameter int                       DATA_WIDTH             = 64,
   parameter int                       ID_WIDTH               = 4,
   parameter int                       OUTSTANDING_FIFO_DEPTH = 16,
   parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS            = '0,
   parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDRESS            = 'h0000_2FFF
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [ID_WIDTH-1:0]       awid,
   input  logic [ADDRESS_WIDTH-1:0]  awaddr,
   input  logic [7:0]                awlen,
   input  logic [2:0]                awsize,
   input  logic [1:0]                awburst,
   input  logic                      awvalid,
   output logic                      awready,
   input  logic [DATA_WIDTH-1:0]     wdata,
   input  logic [DATA_WIDTH/8-1:0]   wstrb,
   input  logic                      wlast,
   input  logic                      wvalid,
   output logic                      wready,
   output logic [ID_WIDTH-1:0]       bid,
   output logic [1:0]                bresp,
   output logic                      bvalid,
   input  logic                      bready,
   output logic                      mem_we,
   output logic [ADDRESS_WIDTH-1:0]  mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_wstrb
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int MAX_SIZE   = $clog2(STRB_WIDTH);

   typedef struct packed {
      logic [ID_WIDTH-1:0]      id;
      logic [ADDRESS_WIDTH-1:0] addr;
      logic [7:0]               len;
      awsize_e                  size;
      awburst_e                 burst;
   } aw_entry_t;

   localparam int ENTRY_WIDTH = $bits(aw_entry_t);

   aw_entry_t push_entry;
   aw_entry_t head;
   logic      fifo_full;
   logic      fifo_empty;
   logic      push;
   logic      pop;

   write_responder_state_e state;

   logic [ID_WIDTH-1:0]      cur_id;
   logic [ADDRESS_WIDTH-1:0] cur_addr;
   logic [7:0]               cur_len;
   awsize_e                  cur_size;
   awburst_e                 cur_burst;
   logic [ADDRESS_WIDTH-1:0] wrap_lower;
   logic [ADDRESS_WIDTH-1:0] wrap_end;
   logic                     cur_decerr;
   logic [7:0]               beat_cnt;

   logic [ADDRESS_WIDTH-1:0] head_size;
   logic [ADDRESS_WIDTH-1:0] head_total;
   logic [ADDRESS_WIDTH-1:0] head_lower;
   logic                     head_decerr;

   logic [ADDRESS_WIDTH-1:0] beat_size;
   logic [ADDRESS_WIDTH-1:0] addr_plus;
   logic [ADDRESS_WIDTH-1:0] next_addr;
   logic                     beat_hs;
   logic                     burst_end;

   // awready depends only on the queue state, so a same-cycle pop never reopens a full queue.
   assign awready = !fifo_full && !areset;
   assign push    = awvalid && awready;
   assign pop     = (state == W_IDLE) && !fifo_empty;

   assign push_entry = '{id:    awid,
                         addr:  awaddr,
                         len:   awlen,
                         size:  awsize_e'(awsize),
                         burst: awburst_e'(awburst)};

   axi4_slave_aw_fifo #(
      .WIDTH (ENTRY_WIDTH),
      .DEPTH (OUTSTANDING_FIFO_DEPTH)
   ) u_aw_fifo (
      .clk       (aclk),
      .reset     (areset),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Decode of the queue head, captured when it is popped.
   assign head_size  = ADDRESS_WIDTH'(1) << head.size;
   assign head_total = head_size * (ADDRESS_WIDTH'(head.len) + ADDRESS_WIDTH'(1));
   assign head_lower = head.addr & ~(head_total - ADDRESS_WIDTH'(1));

   always_comb begin
      head_decerr = 1'b0;
      // Single unsigned range test covers both the low and high decode limits.
      if ((head.addr - MIN_ADDRESS) > (MAX_ADDRESS - MIN_ADDRESS)) begin
         head_decerr = 1'b1;
      end
      if (head.burst == BURST_RESERVED) begin
         head_decerr = 1'b1;
      end
      if (int'(head.size) > MAX_SIZE) begin
         head_decerr = 1'b1;
      end
      if ((head.burst == BURST_WRAP) && !wrap_len_legal(head.len)) begin
         head_decerr = 1'b1;
      end
   end

   assign beat_size = ADDRESS_WIDTH'(1) << cur_size;
   assign addr_plus = cur_addr + beat_size;

   always_comb begin
      next_addr = cur_addr;
      case (cur_burst)
         BURST_INCR: next_addr = (cur_addr & ~(beat_size - ADDRESS_WIDTH'(1))) + beat_size;
         BURST_WRAP: next_addr = (addr_plus == wrap_end) ? wrap_lower : addr_plus;
         default:    next_addr = cur_addr;
      endcase
   end

   assign beat_hs   = wvalid && wready;
   assign burst_end = wlast || (beat_cnt == cur_len);

   always_ff @(posedge aclk) begin
      if (areset) begin
         state      <= W_IDLE;
         wready     <= 1'b0;
         bvalid     <= 1'b0;
         bid        <= '0;
         bresp      <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_wstrb  <= '0;
         cur_id     <= '0;
         cur_addr   <= '0;
         cur_len    <= '0;
         cur_size   <= SIZE_1B;
         cur_burst  <= BURST_FIXED;
         wrap_lower <= '0;
         wrap_end   <= '0;
         cur_decerr <= 1'b0;
         beat_cnt   <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            W_IDLE: begin
               if (!fifo_empty) begin
                  cur_id     <= head.id;
                  cur_addr   <= head.addr;
                  cur_len    <= head.len;
                  cur_size   <= head.size;
                  cur_burst  <= head.burst;
                  wrap_lower <= head_lower;
                  wrap_end   <= head_lower + head_total;
                  cur_decerr <= head_decerr;
                  beat_cnt   <= '0;
                  wready     <= 1'b1;
                  state      <= W_DATA;
               end
            end
            W_DATA: begin
               if (beat_hs) begin
                  // Decode-error bursts still drain their beats but never touch memory.
                  mem_we    <= !cur_decerr;
                  mem_addr  <= cur_addr;
                  mem_wdata <= wdata;
                  mem_wstrb <= wstrb;
                  cur_addr  <= next_addr;
                  beat_cnt  <= beat_cnt + 8'd1;
                  if (burst_end) begin
                     wready <= 1'b0;
                     bvalid <= 1'b1;
                     bid    <= cur_id;
                     if (cur_decerr) begin
                        bresp <= RESP_DECERR;
                     end else if (wlast && (beat_cnt == cur_len)) begin
                        bresp <= RESP_OKAY;
                     end else begin
                        bresp <= RESP_SLVERR;
                     end
                     state <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready) begin
                  bvalid <= 1'b0;
                  state  <= W_IDLE;
               end
            end
            default: state <= W_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_slave_write_responder.sv
// Bench for axi4_slave_write_responder: directed bursts with literal expectations plus
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_axi4_slave_write_responder;
   import axi4_globals_pkg::*;

   localparam int AW = 32;
   localparam int DW = 64;
   localparam int IW = 4;
   localparam int SW = DW / 8;
   localparam int DEPTH = 16;
   localparam int NRAND = 40;

   logic          aclk = 1'b0;
   logic          areset = 1'b1;
   logic [IW-1:0] awid = '0;
   logic [AW-1:0] awaddr = '0;
   logic [7:0]    awlen = '0;
   logic [2:0]    awsize = '0;
   logic [1:0]    awburst = '0;
   logic          awvalid = 1'b0;
   logic          awready;
   logic [DW-1:0] wdata = '0;
   logic [SW-1:0] wstrb = '0;
   logic          wlast = 1'b0;
   logic          wvalid = 1'b0;
   logic          wready;
   logic [IW-1:0] bid;
   logic [1:0]    bresp;
   logic          bvalid;
   logic          bready = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [SW-1:0] mem_wstrb;

   always #5 aclk = ~aclk;

   axi4_slave_write_responder dut (
      .aclk(aclk), .areset(areset),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
   );

   int total = 0;
   int passed = 0;
   int cyc = 0;
   logic chk_en = 1'b0;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic timeout_fail(input string name);
      total++;
      $display("FAIL %s: DUT did not respond within the cycle budget (t=%0t)", name, $time);
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } aw_t;

   aw_t         mq[$];
   aw_t         mcur;
   aw_t         mnew;
   int          mphase = 0;   // 0 waiting for a request, 1 taking beats, 2 holding B
   int          mbeat = 0;
   logic        mdec = 1'b0;
   logic        mpush;
   logic        exp_wready = 1'b0;
   logic        exp_bvalid = 1'b0;
   logic        exp_mem_we = 1'b0;
   logic [3:0]  exp_bid = '0;
   logic [1:0]  exp_bresp = '0;
   logic [31:0] exp_mem_addr = '0;
   logic [63:0] exp_wd = '0;
   logic [7:0]  exp_ws = '0;

   function automatic logic is_decerr(input aw_t a);
      return (a.addr > 32'h2FFF) || (a.burst == 2'b11) || (a.size > 3'd3) ||
             ((a.burst == 2'b10) && !(a.len == 8'd1 || a.len == 8'd3 || a.len == 8'd7 || a.len == 8'd15));
   endfunction

   function automatic logic [31:0] beat_addr(input aw_t a, input int n);
      logic [31:0] sz, al, tot, lower;
      sz    = 32'd1 << a.size;
      al    = a.addr & ~(sz - 32'd1);
      tot   = sz * (32'(a.len) + 32'd1);
      lower = (a.addr / tot) * tot;
      case (a.burst)
         2'b00:   return a.addr;
         2'b01:   return (n == 0) ? a.addr : al + 32'(n) * sz;
         default: return lower + ((a.addr - lower + 32'(n) * sz) % tot);
      endcase
   endfunction

   always @(posedge aclk) begin
      if (areset) begin
         mq.delete();
         mphase     = 0;
         exp_wready = 1'b0;
         exp_bvalid = 1'b0;
         exp_mem_we = 1'b0;
         exp_bid    = '0;
         exp_bresp  = '0;
      end else begin
         mpush = awvalid && (mq.size() < DEPTH);
         mnew  = '{awid, awaddr, awlen, awsize, awburst};
         exp_mem_we = 1'b0;
         if (mphase == 0) begin
            if (mq.size() > 0) begin
               mcur = mq.pop_front();
               mdec = is_decerr(mcur);
               mbeat = 0;
               exp_wready = 1'b1;
               mphase = 1;
            end
         end else if (mphase == 1) begin
            if (wvalid) begin
               exp_mem_we   = !mdec;
               exp_mem_addr = beat_addr(mcur, mbeat);
               exp_wd       = wdata;
               exp_ws       = wstrb;
               if (wlast || mbeat == int'(mcur.len)) begin
                  exp_wready = 1'b0;
                  exp_bvalid = 1'b1;
                  exp_bid    = mcur.id;
                  exp_bresp  = mdec ? 2'b11 : ((wlast && mbeat == int'(mcur.len)) ? 2'b00 : 2'b10);
                  mphase     = 2;
               end else begin
                  mbeat++;
               end
            end
         end else begin
            if (bready) begin
               exp_bvalid = 1'b0;
               mphase = 0;
            end
         end
         if (mpush) mq.push_back(mnew);
      end
   end

   // ---------------- per-cycle compare and logging ----------------
   logic [31:0] mem_log[$];
   logic [5:0]  b_log[$];
   int          bv_rise_cyc = -1;
   int          mem_cyc = -1;
   logic        bv_prev = 1'b0;

   always @(negedge aclk) begin
      if (chk_en) begin
         check("awready", awready, !areset && (mq.size() < DEPTH));
         check("wready", wready, exp_wready);
         check("bvalid", bvalid, exp_bvalid);
         check("mem_we", mem_we, exp_mem_we);
         if (exp_bvalid) begin
            check("bid", bid, exp_bid);
            check("bresp", bresp, exp_bresp);
         end
         if (exp_mem_we) begin
            check("mem_addr", mem_addr, exp_mem_addr);
            check("mem_wdata", mem_wdata, exp_wd);
            check("mem_wstrb", mem_wstrb, exp_ws);
         end
         if (mem_we) begin
            mem_log.push_back(mem_addr);
            mem_cyc = cyc;
         end
         if (bvalid && bready) b_log.push_back({bid, bresp});
         if (bvalid && !bv_prev) bv_rise_cyc = cyc;
         bv_prev = bvalid;
      end
   end

   // ---------------- drivers ----------------
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge aclk);
      #1;
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int   n;
      logic acc;
      n = 0;
      acc = 1'b0;
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst;
      awvalid = 1'b1;
      while (!acc && n < 1000) begin
         @(negedge aclk);
         acc = awready;
         @(posedge aclk);
         #1;
         n++;
      end
      awvalid = 1'b0;
      if (!acc) timeout_fail("aw_handshake");
   endtask

   task automatic send_w(input logic [63:0] d, input logic [7:0] s, input logic l, output int hs);
      int   n;
      logic acc;
      n = 0;
      acc = 1'b0;
      hs = -1;
      wdata = d; wstrb = s; wlast = l;
      wvalid = 1'b1;
      while (!acc && n < 1000) begin
         @(negedge aclk);
         acc = wready;
         if (acc) hs = cyc;
         @(posedge aclk);
         #1;
         n++;
      end
      wvalid = 1'b0;
      wlast = 1'b0;
      if (!acc) timeout_fail("w_handshake");
   endtask

   task automatic clear_logs();
      mem_log.delete();
      b_log.delete();
   endtask

   // ---------------- random traffic plan ----------------
   int   plan_nb[$];
   int   plan_last[$];
   logic w_done = 1'b0;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int hs;
      int c0;
      areset = 1'b1;
      @(posedge aclk);
      #1;
      chk_en = 1'b1;
      @(negedge aclk);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_bid", bid, 0);
      check("rst_bresp", bresp, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_wstrb", mem_wstrb, 0);
      @(posedge aclk);
      #1;
      areset = 1'b0;
      @(negedge aclk);
      check("post_rst_awready", awready, 1);
      @(posedge aclk);
      #1;

      // INCR burst, latency of B and last memory write
      bready = 1'b1;
      clear_logs();
      send_aw(4'd5, 32'h100, 8'd3, 3'd3, 2'b01);
      for (int i = 0; i < 4; i++) send_w(64'hA0 + 64'(i), 8'hFF, i == 3, hs);
      wait_cycles(3);
      check("incr_beats", mem_log.size(), 4);
      if (mem_log.size() == 4) begin
         check("incr_addr0", mem_log[0], 32'h100);
         check("incr_addr1", mem_log[1], 32'h108);
         check("incr_addr2", mem_log[2], 32'h110);
         check("incr_addr3", mem_log[3], 32'h118);
      end
      check("incr_bvalid_lat", bv_rise_cyc, hs + 1);
      check("incr_memwe_lat", mem_cyc, hs + 1);
      check("incr_bcount", b_log.size(), 1);
      if (b_log.size() == 1) check("incr_b", b_log[0], {4'd5, 2'b00});

      // WRAP burst
      clear_logs();
      send_aw(4'd6, 32'h118, 8'd3, 3'd3, 2'b10);
      for (int i = 0; i < 4; i++) send_w(64'hB0 + 64'(i), 8'h0F, i == 3, hs);
      wait_cycles(3);
      check("wrap_beats", mem_log.size(), 4);
      if (mem_log.size() == 4) begin
         check("wrap_addr0", mem_log[0], 32'h118);
         check("wrap_addr1", mem_log[1], 32'h100);
         check("wrap_addr2", mem_log[2], 32'h108);
         check("wrap_addr3", mem_log[3], 32'h110);
      end
      check("wrap_bcount", b_log.size(), 1);
      if (b_log.size() == 1) check("wrap_b", b_log[0], {4'd6, 2'b00});

      // Out-of-range address: beats drained, no memory writes
      clear_logs();
      send_aw(4'd1, 32'h4000, 8'd1, 3'd3, 2'b01);
      for (int i = 0; i < 2; i++) send_w(64'hC0 + 64'(i), 8'hFF, i == 1, hs);
      wait_cycles(3);
      check("decerr_no_we", mem_log.size(), 0);
      check("decerr_bcount", b_log.size(), 1);
      if (b_log.size() == 1) check("decerr_b", b_log[0], {4'd1, 2'b11});

      // Early wlast then a normal queued burst
      clear_logs();
      send_aw(4'd7, 32'h300, 8'd3, 3'd3, 2'b01);
      send_aw(4'd8, 32'h400, 8'd1, 3'd3, 2'b01);
      send_w(64'hD0, 8'hFF, 1'b0, hs);
      send_w(64'hD1, 8'hFF, 1'b1, hs);
      send_w(64'hD2, 8'hFF, 1'b0, hs);
      send_w(64'hD3, 8'hFF, 1'b1, hs);
      wait_cycles(3);
      check("slverr_beats", mem_log.size(), 4);
      if (mem_log.size() == 4) begin
         check("slverr_addr1", mem_log[1], 32'h308);
         check("next_addr0", mem_log[2], 32'h400);
         check("next_addr1", mem_log[3], 32'h408);
      end
      check("slverr_bcount", b_log.size(), 2);
      if (b_log.size() == 2) begin
         check("slverr_b", b_log[0], {4'd7, 2'b10});
         check("after_slverr_b", b_log[1], {4'd8, 2'b00});
      end

      // Fill the outstanding queue while B is stalled
      clear_logs();
      bready = 1'b0;
      c0 = cyc;
      for (int i = 0; i < 17; i++) send_aw(4'(i), 32'h800 + 32'(i) * 8, 8'd0, 3'd3, 2'b01);
      check("fill_17_cycles", cyc - c0, 17);
      @(negedge aclk);
      check("fill_awready_low", awready, 0);
      @(posedge aclk);
      #1;
      send_w(64'hE0, 8'hFF, 1'b1, hs);
      wait_cycles(2);
      check("fill_still_full", awready, 0);
      bready = 1'b1;
      for (int i = 1; i < 17; i++) send_w(64'hE0 + 64'(i), 8'hFF, 1'b1, hs);
      wait_cycles(6);
      check("fill_bcount", b_log.size(), 17);
      if (b_log.size() == 17) begin
         for (int i = 0; i < 17; i++) check("fill_b_order", b_log[i], {4'(i), 2'b00});
      end

      // Reset in the middle of a burst with another request queued
      clear_logs();
      send_aw(4'd2, 32'h200, 8'd7, 3'd3, 2'b01);
      send_aw(4'd3, 32'h280, 8'd1, 3'd3, 2'b01);
      send_w(64'hF0, 8'hFF, 1'b0, hs);
      send_w(64'hF1, 8'hFF, 1'b0, hs);
      areset = 1'b1;
      @(posedge aclk);
      #1;
      areset = 1'b0;
      @(negedge aclk);
      check("midrst_wready", wready, 0);
      check("midrst_bvalid", bvalid, 0);
      check("midrst_mem_we", mem_we, 0);
      check("midrst_awready", awready, 1);
      @(posedge aclk);
      #1;
      clear_logs();
      wait_cycles(10);
      check("midrst_no_b", b_log.size(), 0);
      check("midrst_no_we", mem_log.size(), 0);

      // Randomized traffic against the model
      clear_logs();
      fork
         begin
            for (int i = 0; i < NRAND; i++) begin
               logic [31:0] a;
               logic [7:0]  l;
               logic [2:0]  s;
               logic [1:0]  b;
               int          nb;
               int          lastpos;
               s = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
               b = ($urandom_range(0, 11) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
               if (b == 2'b10) begin
                  case ($urandom_range(0, 4))
                     0: l = 8'd1;
                     1: l = 8'd3;
                     2: l = 8'd7;
                     3: l = 8'd15;
                     default: l = 8'd2;
                  endcase
               end else begin
                  l = 8'($urandom_range(0, 5));
               end
               a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 32'h3100));
               if (b == 2'b10) a = a & ~((32'd1 << s) - 32'd1);
               nb = int'(l) + 1;
               lastpos = nb - 1;
               if (l != 0 && $urandom_range(0, 5) == 0) begin
                  nb = $urandom_range(1, int'(l));
                  lastpos = nb - 1;
               end else if ($urandom_range(0, 7) == 0) begin
                  lastpos = -1;
               end
               plan_nb.push_back(nb);
               plan_last.push_back(lastpos);
               send_aw(4'($urandom_range(0, 15)), a, l, s, b);
               if ($urandom_range(0, 2) == 0) wait_cycles($urandom_range(1, 4));
            end
         end
         begin
            int whs;
            for (int i = 0; i < NRAND; i++) begin
               int n;
               int nb;
               int lp;
               n = 0;
               while (plan_nb.size() == 0 && n < 1000) begin
                  @(posedge aclk);
                  #1;
                  n++;
               end
               if (plan_nb.size() == 0) begin
                  timeout_fail("rand_plan");
                  break;
               end
               nb = plan_nb.pop_front();
               lp = plan_last.pop_front();
               for (int k = 0; k < nb; k++) begin
                  if ($urandom_range(0, 3) == 0) wait_cycles($urandom_range(1, 2));
                  send_w({$urandom, $urandom}, 8'($urandom_range(0, 255)), k == lp, whs);
               end
            end
            w_done = 1'b1;
         end
         begin
            while (!w_done) begin
               @(posedge aclk);
               #1;
               bready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bready = 1'b1;
      wait_cycles(30);
      check("rand_bcount", b_log.size(), NRAND);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
